// File: rtl/ov7670_pixel_capture.sv
// OV7670 parallel-bus capture: oversamples PCLK/HREF/VSYNC/D in the clk domain,
// tracks frame boundaries and assembles bytes into coordinate-tagged pixels.
module ov7670_pixel_capture #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int BYTES_PER_PIXEL = 1,
    parameter int SYNC_STAGES     = 2
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        PCLK,
    input  logic        HREF,
    input  logic        VSYNC,
    input  logic [7:0]  D,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        sof,
    output logic        eol,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err
);

    localparam logic [9:0] X_MAX = 10'(H_ACTIVE);
    localparam logic [8:0] Y_MAX = 9'(V_ACTIVE);
    localparam bit         WIDE  = (BYTES_PER_PIXEL == 2);

    typedef enum logic [1:0] {SYNC_WAIT, VS_HIGH, ACTIVE} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] pclk_sync, href_sync, vsync_sync;
    logic [7:0]             d_sync [SYNC_STAGES];
    logic                   pclk_s, href_s, vsync_s;
    logic                   pclk_d, href_d, vsync_d;

    logic       rise_p1, href_p1, hfall_p1, vrise_p1, vs_p1;
    logic       rise_p2, href_p2, hfall_p2, vrise_p2, vs_p2;
    logic [7:0] d_p1, d_p2;

    logic [9:0]  x;
    logic [8:0]  y;
    logic        phase;
    logic        overflow;
    logic [7:0]  hi_byte;
    logic        byte_in;
    logic [15:0] pix_word;

    assign pclk_s  = pclk_sync[SYNC_STAGES-1];
    assign href_s  = href_sync[SYNC_STAGES-1];
    assign vsync_s = vsync_sync[SYNC_STAGES-1];

    // Synchronizers, edge detection and two event stages that set the fixed output latency
    always_ff @(posedge clk) begin
        if (!reset_) begin
            pclk_sync  <= '0;
            href_sync  <= '0;
            vsync_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) d_sync[i] <= '0;
            pclk_d   <= 1'b0;
            href_d   <= 1'b0;
            vsync_d  <= 1'b0;
            rise_p1  <= 1'b0;
            href_p1  <= 1'b0;
            hfall_p1 <= 1'b0;
            vrise_p1 <= 1'b0;
            vs_p1    <= 1'b0;
            d_p1     <= '0;
            rise_p2  <= 1'b0;
            href_p2  <= 1'b0;
            hfall_p2 <= 1'b0;
            vrise_p2 <= 1'b0;
            vs_p2    <= 1'b0;
            d_p2     <= '0;
        end else begin
            pclk_sync  <= {pclk_sync[SYNC_STAGES-2:0], PCLK};
            href_sync  <= {href_sync[SYNC_STAGES-2:0], HREF};
            vsync_sync <= {vsync_sync[SYNC_STAGES-2:0], VSYNC};
            d_sync[0]  <= D;
            for (int i = 1; i < SYNC_STAGES; i++) d_sync[i] <= d_sync[i-1];
            pclk_d   <= pclk_s;
            href_d   <= href_s;
            vsync_d  <= vsync_s;
            rise_p1  <= pclk_s & ~pclk_d;
            href_p1  <= href_s;
            hfall_p1 <= ~href_s & href_d;
            vrise_p1 <= vsync_s & ~vsync_d;
            vs_p1    <= vsync_s;
            d_p1     <= d_sync[SYNC_STAGES-1];
            rise_p2  <= rise_p1;
            href_p2  <= href_p1;
            hfall_p2 <= hfall_p1;
            vrise_p2 <= vrise_p1;
            vs_p2    <= vs_p1;
            d_p2     <= d_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) state <= SYNC_WAIT;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SYNC_WAIT: if (vs_p2)    state_nxt = VS_HIGH;
            VS_HIGH:   if (!vs_p2)   state_nxt = ACTIVE;
            ACTIVE:    if (vrise_p2) state_nxt = VS_HIGH;
            default:                 state_nxt = SYNC_WAIT;
        endcase
    end

    assign byte_in  = (state == ACTIVE) && rise_p2 && href_p2 && !vrise_p2 && !hfall_p2;
    assign pix_word = WIDE ? {hi_byte, d_p2} : {8'h00, d_p2};

    // Overflow remembers pixels dropped past the line end, so long lines still flag line_err
    always_ff @(posedge clk) begin
        if (!reset_) begin
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
            x          <= '0;
            y          <= '0;
            phase      <= 1'b0;
            overflow   <= 1'b0;
            hi_byte    <= '0;
        end else begin
            pix_valid  <= 1'b0;
            line_err   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (state != ACTIVE) begin
                x        <= '0;
                y        <= '0;
                phase    <= 1'b0;
                overflow <= 1'b0;
            end else if (vrise_p2) begin
                frame_done <= 1'b1;
                frame_err  <= (y != Y_MAX);
            end else if (hfall_p2) begin
                if (y < Y_MAX) begin
                    line_err <= (x != X_MAX) || phase || overflow;
                    y        <= y + 9'd1;
                end
                x        <= '0;
                phase    <= 1'b0;
                overflow <= 1'b0;
            end else if (byte_in) begin
                if (WIDE && !phase) begin
                    hi_byte <= d_p2;
                    phase   <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (x < X_MAX) begin
                        if (y < Y_MAX) begin
                            pix_valid <= 1'b1;
                            pix_data  <= pix_word;
                            pix_x     <= x;
                            pix_y     <= y;
                            sof       <= (x == '0) && (y == '0);
                            eol       <= (x == X_MAX - 10'd1);
                        end
                        x <= x + 10'd1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Bench for ov7670_pixel_capture: raw and RGB565 instances share one camera stream;
// expected events come from a line/byte-count model of the capture rules.
module tb_ov7670_pixel_capture;

    localparam int H   = 4;
    localparam int V   = 3;
    localparam int SS  = 2;
    localparam int LAT = SS + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_, PCLK, HREF, VSYNC;
    logic [7:0] D;

    logic        r_pix_valid, r_sof, r_eol, r_frame_done, r_line_err, r_frame_err;
    logic [15:0] r_pix_data;
    logic [9:0]  r_pix_x;
    logic [8:0]  r_pix_y;
    logic        g_pix_valid, g_sof, g_eol, g_frame_done, g_line_err, g_frame_err;
    logic [15:0] g_pix_data;
    logic [9:0]  g_pix_x;
    logic [8:0]  g_pix_y;

    ov7670_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .BYTES_PER_PIXEL(1), .SYNC_STAGES(SS)) dut_raw (
        .clk(clk), .reset_(reset_), .PCLK(PCLK), .HREF(HREF), .VSYNC(VSYNC), .D(D),
        .pix_valid(r_pix_valid), .pix_data(r_pix_data), .pix_x(r_pix_x), .pix_y(r_pix_y),
        .sof(r_sof), .eol(r_eol), .frame_done(r_frame_done), .line_err(r_line_err),
        .frame_err(r_frame_err));

    ov7670_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .BYTES_PER_PIXEL(2), .SYNC_STAGES(SS)) dut_rgb (
        .clk(clk), .reset_(reset_), .PCLK(PCLK), .HREF(HREF), .VSYNC(VSYNC), .D(D),
        .pix_valid(g_pix_valid), .pix_data(g_pix_data), .pix_x(g_pix_x), .pix_y(g_pix_y),
        .sof(g_sof), .eol(g_eol), .frame_done(g_frame_done), .line_err(g_line_err),
        .frame_err(g_frame_err));

    typedef struct {
        int          dut;
        int          kind;
        logic [15:0] data;
        int          x;
        int          y;
        bit          sof;
        bit          eol;
        bit          ferr;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    bit         capturing;
    int         y_line;
    int         bi;
    logic [7:0] prev_byte;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mkEv(int dut, int kind, logic [15:0] data, int x, int y,
                                 bit sof, bit eol, bit ferr, int c);
        ev_t e;
        e.dut = dut; e.kind = kind; e.data = data; e.x = x; e.y = y;
        e.sof = sof; e.eol = eol; e.ferr = ferr; e.cyc = c;
        return e;
    endfunction

    // Record every output event of both instances with its cycle stamp
    always @(negedge clk) begin
        if (r_pix_valid === 1'b1)
            obs_q.push_back(mkEv(0, 0, r_pix_data, int'(r_pix_x), int'(r_pix_y), r_sof, r_eol, 1'b0, cyc));
        if (r_line_err === 1'b1)
            obs_q.push_back(mkEv(0, 1, 16'h0, 0, 0, 1'b0, 1'b0, 1'b0, cyc));
        if (r_frame_done === 1'b1)
            obs_q.push_back(mkEv(0, 2, 16'h0, 0, 0, 1'b0, 1'b0, r_frame_err, cyc));
        else if (r_frame_err === 1'b1)
            obs_q.push_back(mkEv(0, 3, 16'h0, 0, 0, 1'b0, 1'b0, 1'b1, cyc));
        if (g_pix_valid === 1'b1)
            obs_q.push_back(mkEv(1, 0, g_pix_data, int'(g_pix_x), int'(g_pix_y), g_sof, g_eol, 1'b0, cyc));
        if (g_line_err === 1'b1)
            obs_q.push_back(mkEv(1, 1, 16'h0, 0, 0, 1'b0, 1'b0, 1'b0, cyc));
        if (g_frame_done === 1'b1)
            obs_q.push_back(mkEv(1, 2, 16'h0, 0, 0, 1'b0, 1'b0, g_frame_err, cyc));
        else if (g_frame_err === 1'b1)
            obs_q.push_back(mkEv(1, 3, 16'h0, 0, 0, 1'b0, 1'b0, 1'b1, cyc));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One camera byte: data changes with PCLK low, sampled on the PCLK rise
    task automatic applyStimulus(input logic [7:0] b);
        int rc;
        int bpp;
        int p;
        @(negedge clk);
        PCLK = 1'b0; D = b; HREF = 1'b1;
        repeat (3) @(negedge clk);
        PCLK = 1'b1;
        rc = cyc;
        if (capturing) begin
            for (int k = 0; k < 2; k++) begin
                bpp = k + 1;
                if (bi % bpp == bpp - 1) begin
                    p = bi / bpp;
                    if (p < H && y_line < V)
                        exp_q.push_back(mkEv(k, 0, (bpp == 1) ? {8'h00, b} : {prev_byte, b}, p, y_line,
                                             (p == 0 && y_line == 0), (p == H - 1), 1'b0, rc + LAT));
                end
            end
        end
        prev_byte = b;
        bi++;
        repeat (3) @(negedge clk);
    endtask

    task automatic endLine();
        int rc;
        @(negedge clk);
        PCLK = 1'b0; HREF = 1'b0;
        rc = cyc;
        if (capturing && y_line < V) begin
            for (int k = 0; k < 2; k++)
                if (bi != H * (k + 1))
                    exp_q.push_back(mkEv(k, 1, 16'h0, 0, 0, 1'b0, 1'b0, 1'b0, rc + LAT));
            y_line++;
        end
        bi = 0;
        repeat (10) @(negedge clk);
    endtask

    task automatic sendLine(input int n);
        for (int i = 0; i < n; i++) applyStimulus(8'($urandom));
        endLine();
    endtask

    task automatic vsyncRise();
        int rc;
        @(negedge clk);
        VSYNC = 1'b1;
        rc = cyc;
        if (capturing)
            for (int k = 0; k < 2; k++)
                exp_q.push_back(mkEv(k, 2, 16'h0, 0, 0, 1'b0, 1'b0, (y_line != V), rc + LAT));
        capturing = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic vsyncFall();
        @(negedge clk);
        VSYNC = 1'b0;
        capturing = 1'b1;
        y_line = 0;
        repeat (10) @(negedge clk);
    endtask

    task automatic doReset();
        repeat (8) @(negedge clk);
        reset_ = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_raw_outputs", 64'({r_pix_valid, r_pix_data, r_pix_x, r_pix_y, r_sof, r_eol,
                                      r_frame_done, r_line_err, r_frame_err}), 64'd0);
        chk("reset_rgb_outputs", 64'({g_pix_valid, g_pix_data, g_pix_x, g_pix_y, g_sof, g_eol,
                                      g_frame_done, g_line_err, g_frame_err}), 64'd0);
        reset_ = 1'b1;
        capturing = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        int n;
        repeat (12) @(negedge clk);
        chk({tag, ".count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d].dut", tag, i),  64'(obs_q[i].dut),  64'(exp_q[i].dut));
            chk($sformatf("%s[%0d].kind", tag, i), 64'(obs_q[i].kind), 64'(exp_q[i].kind));
            chk($sformatf("%s[%0d].cyc", tag, i),  64'(obs_q[i].cyc),  64'(exp_q[i].cyc));
            if (exp_q[i].kind == 0) begin
                chk($sformatf("%s[%0d].data", tag, i), 64'(obs_q[i].data), 64'(exp_q[i].data));
                chk($sformatf("%s[%0d].x", tag, i),    64'(obs_q[i].x),    64'(exp_q[i].x));
                chk($sformatf("%s[%0d].y", tag, i),    64'(obs_q[i].y),    64'(exp_q[i].y));
                chk($sformatf("%s[%0d].sof", tag, i),  64'(obs_q[i].sof),  64'(exp_q[i].sof));
                chk($sformatf("%s[%0d].eol", tag, i),  64'(obs_q[i].eol),  64'(exp_q[i].eol));
            end
            if (exp_q[i].kind == 2)
                chk($sformatf("%s[%0d].frame_err", tag, i), 64'(obs_q[i].ferr), 64'(exp_q[i].ferr));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int nl;
        reset_ = 1'b0; PCLK = 1'b0; HREF = 1'b0; VSYNC = 1'b0; D = 8'h00;
        capturing = 1'b0; y_line = 0; bi = 0; prev_byte = 8'h00;
        doReset();
        vsyncRise();
        vsyncFall();

        $display("[TB] raw frame 0x10..0x1B");
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 4; i++) applyStimulus(8'(8'h10 + 4 * l + i));
            endLine();
        end
        vsyncRise();
        checkOutput("raw_frame");
        vsyncFall();

        $display("[TB] RGB565 frame starting F8 1F 07 E0");
        applyStimulus(8'hF8); applyStimulus(8'h1F); applyStimulus(8'h07); applyStimulus(8'hE0);
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom));
        endLine();
        sendLine(8);
        sendLine(8);
        vsyncRise();
        checkOutput("rgb_frame");
        vsyncFall();

        $display("[TB] short, long and nominal lines");
        sendLine(3);
        sendLine(6);
        sendLine(4);
        vsyncRise();
        checkOutput("short_long");
        vsyncFall();

        $display("[TB] frame ending after two lines");
        sendLine(4);
        sendLine(4);
        vsyncRise();
        checkOutput("short_frame");
        vsyncFall();

        $display("[TB] random frames");
        for (int f = 0; f < 3; f++) begin
            nl = int'($urandom_range(1, 5));
            for (int l = 0; l < nl; l++) sendLine(int'($urandom_range(1, 10)));
            vsyncRise();
            checkOutput($sformatf("random_frame%0d", f));
            vsyncFall();
        end

        $display("[TB] VSYNC rising mid-line");
        sendLine(8);
        for (int i = 0; i < 3; i++) applyStimulus(8'($urandom));
        vsyncRise();
        endLine();
        checkOutput("midline_vsync");
        vsyncFall();

        $display("[TB] reset mid-frame");
        sendLine(4);
        applyStimulus(8'($urandom));
        applyStimulus(8'($urandom));
        doReset();
        applyStimulus(8'($urandom));
        applyStimulus(8'($urandom));
        endLine();
        sendLine(4);
        vsyncRise();
        vsyncFall();
        sendLine(8);
        sendLine(4);
        sendLine(8);
        vsyncRise();
        checkOutput("after_reset");
        vsyncFall();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ov7670_pixel_capture.md
# ov7670_pixel_capture

Single-clock capture stage directly downstream of the OV7670 camera driver's parallel video pins (PCLK, HREF, VSYNC, D[7:0]). It oversamples the camera bus in the system clock domain, locks onto frame boundaries, and assembles bytes into pixels. Pixels are emitted as a valid-pulsed stream with x/y coordinates and frame/line markers for the demosaicing pipeline. Malformed lines and frames are flagged, never stalled; the camera cannot be back-pressured.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- BYTES_PER_PIXEL, 1, 1 = raw Bayer (8-bit), 2 = RGB565 (16-bit)
- SYNC_STAGES, 2, synchronizer depth on all camera inputs (≥2)

Ports:
- clk  in  1  system clock; must be ≥4× PCLK frequency
- reset_  in  1  active-low reset, synchronous to clk
- PCLK  in  1  camera pixel clock (asynchronous, treated as data)
- HREF  in  1  camera line-valid
- VSYNC  in  1  camera frame sync, high between frames
- D  in  8  camera data
- pix_valid  out  1  one-cycle pulse, pixel complete
- pix_data  out  16  pixel; raw mode uses [7:0], [15:8]=0
- pix_x  out  10  column of current pixel
- pix_y  out  9  row of current pixel
- sof  out  1  high with pix_valid of pixel (0,0)
- eol  out  1  high with pix_valid of pixel x=H_ACTIVE-1
- frame_done  out  1  one-cycle pulse at end of captured frame
- line_err  out  1  one-cycle pulse, line length ≠ H_ACTIVE
- frame_err  out  1  one-cycle pulse with frame_done, line count ≠ V_ACTIVE

## Operation
- PCLK, HREF, VSYNC, D each pass through SYNC_STAGES flops. PCLK rising edge = synchronized PCLK high and its one-cycle-delayed copy low. HREF/D are taken from the same stage as the synchronized PCLK.
- States:
  - SYNC_WAIT: entered on reset; wait for synced VSYNC high → VS_HIGH.
  - VS_HIGH: wait for VSYNC low → ACTIVE; clear x, y, byte phase.
  - ACTIVE: capture; synced VSYNC rising → pulse frame_done → VS_HIGH.
- Capture, ACTIVE only: on a PCLK rising edge with HREF high, latch D.
  - BYTES_PER_PIXEL=2: first byte → [15:8], second → [7:0]; pixel completes on the second byte.
  - BYTES_PER_PIXEL=1: every byte completes a pixel.
- Pixel complete with x<H_ACTIVE and y<V_ACTIVE: pulse pix_valid; present pix_x=x, pix_y=y; then increment x.
- Pixels with x≥H_ACTIVE or y≥V_ACTIVE are dropped. The counter x saturates at H_ACTIVE.
- HREF falling edge (synced, clk domain) in ACTIVE:
  - line_err pulses if x≠H_ACTIVE or a half pixel is pending.
  - Then x←0, byte phase←0, y←y+1 (saturating at V_ACTIVE).
- Lines with y≥V_ACTIVE are not counted for line_err.
- frame_err pulses with frame_done when y≠V_ACTIVE at VSYNC rising.
- VSYNC rising mid-line (HREF high) ends the frame. The partial line is discarded and does not count toward y; no line_err.
- Reset mid-frame: return to SYNC_WAIT; no output until the next full VSYNC high→low cycle.

## Timing
- Reset values: all outputs 0, state SYNC_WAIT.
- All outputs are registered.
- pix_valid asserts SYNC_STAGES+2 clk cycles after the first clk edge that samples PCLK high at the pin, on the completing byte.
- pix_data, pix_x, pix_y, sof, eol are valid only while pix_valid=1 and hold their values between pulses.
- line_err asserts SYNC_STAGES+2 cycles after the HREF fall reaches the pin. It never coincides with pix_valid, since the camera holds HREF low for ≥1 PCLK.
- frame_done/frame_err assert SYNC_STAGES+2 cycles after VSYNC rise.
- At most one pix_valid per PCLK period.

## Test plan
- Raw mode, H_ACTIVE=4, V_ACTIVE=3, bytes 0x10..0x1B over 3 lines → 12 pix_valid, data 0x10..0x1B, x 0..3, y 0..2; sof once at first pixel, eol at 0x13/0x17/0x1B; one frame_done; no errors.
- BYTES_PER_PIXEL=2, bytes 0xF8,0x1F,0x07,0xE0 → pix_data 0xF81F (x=0), then 0x07E0 (x=1).
- Reset released while HREF is active mid-frame → zero pix_valid until VSYNC pulses high then low; the next frame is captured normally from (0,0).
- Short line, 3 bytes with H_ACTIVE=4 → 3 pix_valid, line_err pulse at HREF fall; next line starts x=0 at y+1.
- Long line, 6 bytes → only 4 pix_valid (x 0..3), line_err pulse; pixels 5–6 dropped.
- VSYNC rises after 2 lines with V_ACTIVE=3 → frame_done and frame_err in the same cycle; the next frame restarts at y=0.
